// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: captures the memory-stage bundle, selects the
// writeback value, and keeps saturating retired-instruction and retired-load counters.
module mem_wb_stage #(
  parameter int CNT_WIDTH  = 32,
  parameter int DEST_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freeze_in,
  input  logic                  flush_in,
  input  logic                  valid_in,
  input  logic                  wb_enable_in,
  input  logic                  mem_read_enable_in,
  input  logic [31:0]           alu_res_in,
  input  logic [31:0]           mem_result_in,
  input  logic [DEST_WIDTH-1:0] dest_in,
  output logic                  wb_enable_out,
  output logic [DEST_WIDTH-1:0] wb_dest_out,
  output logic [31:0]           wb_value_out,
  output logic                  mem_read_out,
  output logic [31:0]           alu_res_out,
  output logic [CNT_WIDTH-1:0]  retired_count_out,
  output logic [CNT_WIDTH-1:0]  load_count_out
);

  logic                  valid_r;
  logic                  wb_en_r;
  logic                  mem_rd_r;
  logic [31:0]           alu_r;
  logic [31:0]           mem_r;
  logic [DEST_WIDTH-1:0] dest_r;
  logic [CNT_WIDTH-1:0]  retired_cnt;
  logic [CNT_WIDTH-1:0]  load_cnt;

  // Saturating increment: counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] cnt);
    if (cnt == {CNT_WIDTH{1'b1}}) begin
      sat_inc = cnt;
    end else begin
      sat_inc = cnt + CNT_WIDTH'(1);
    end
  endfunction

  // Stage registers: rst > flush > freeze > normal capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r     <= 1'b0;
      wb_en_r     <= 1'b0;
      mem_rd_r    <= 1'b0;
      alu_r       <= 32'h0000_0000;
      mem_r       <= 32'h0000_0000;
      dest_r      <= '0;
      retired_cnt <= '0;
      load_cnt    <= '0;
    end else if (flush_in) begin
      valid_r     <= 1'b0;
      wb_en_r     <= 1'b0;
      mem_rd_r    <= 1'b0;
      alu_r       <= 32'h0000_0000;
      mem_r       <= 32'h0000_0000;
      dest_r      <= '0;
    end else if (freeze_in) begin
      valid_r     <= valid_r;
      wb_en_r     <= wb_en_r;
      mem_rd_r    <= mem_rd_r;
      alu_r       <= alu_r;
      mem_r       <= mem_r;
      dest_r      <= dest_r;
    end else begin
      valid_r  <= valid_in;
      wb_en_r  <= wb_enable_in & valid_in;
      mem_rd_r <= mem_read_enable_in & valid_in;
      alu_r    <= alu_res_in;
      mem_r    <= mem_result_in;
      dest_r   <= dest_in;
      if (valid_in) begin
        retired_cnt <= sat_inc(retired_cnt);
      end else begin
        retired_cnt <= retired_cnt;
      end
      if (valid_in && mem_read_enable_in) begin
        load_cnt <= sat_inc(load_cnt);
      end else begin
        load_cnt <= load_cnt;
      end
    end
  end

  // wb_en_r already implies valid_r; the AND keeps the write strictly tied to a real instruction.
  always_comb begin
    wb_enable_out     = wb_en_r & valid_r;
    wb_dest_out       = dest_r;
    mem_read_out      = mem_rd_r;
    alu_res_out       = alu_r;
    retired_count_out = retired_cnt;
    load_count_out    = load_cnt;
    if (mem_rd_r) begin
      wb_value_out = mem_r;
    end else begin
      wb_value_out = alu_r;
    end
  end

endmodule
